// File: rtl/pio_irq_service_master.sv
// Avalon-MM initiator for one PIO responder: initialises it, services its
// irq, publishes captured edges as events, and forwards fabric write commands.
module pio_irq_service_master #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] DIR_INIT      = '0,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT = WIDTH'(8'hFF),
  parameter int               READ_LATENCY  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_bits,
  output logic             evt_overflow,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             busy
);

  typedef enum logic [2:0] {
    INIT_DIR,
    INIT_MASK,
    IDLE,
    CMD_WR,
    RD_ADDR,
    RD_WAIT,
    CLR_WR
  } state_t;

  localparam logic [31:0] RD_MASK = 32'({WIDTH{1'b1}});
  localparam logic [15:0] WAIT_LAST = 16'(READ_LATENCY - 1);

  state_t           state;
  logic             init_go;
  logic             last_irq;
  logic [15:0]      wait_cnt;
  logic [WIDTH-1:0] capture;
  logic [31:0]      rd_masked;
  logic             take_irq;
  logic             post;
  logic             evt_hs;

  function automatic logic [2:0] op_addr(input logic [1:0] op);
    unique case (op)
      2'b00:   op_addr = 3'd0;
      2'b01:   op_addr = 3'd4;
      2'b10:   op_addr = 3'd5;
      default: op_addr = 3'd1;
    endcase
  endfunction

  // Bits above WIDTH never reach the PIO or the event stream.
  assign rd_masked = avm_readdata & RD_MASK;

  // A command that lost to the previous service gets the next slot.
  assign take_irq  = irq_in && !(last_irq && cmd_valid);
  assign cmd_ready = (state == IDLE) && !take_irq;
  assign busy      = (state != IDLE);
  assign post      = (state == CLR_WR);
  assign evt_hs    = evt_valid && evt_ready;

  // Sequencer; bus outputs are loaded together with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT_DIR;
      init_go        <= 1'b0;
      last_irq       <= 1'b0;
      wait_cnt       <= '0;
      capture        <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      unique case (state)
        INIT_DIR: begin
          if (!init_go) begin
            init_go        <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= 3'd1;
            avm_writedata  <= 32'(DIR_INIT);
          end else begin
            state          <= INIT_MASK;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= 3'd2;
            avm_writedata  <= 32'(IRQ_MASK_INIT);
          end
        end
        INIT_MASK: state <= IDLE;
        IDLE: begin
          if (take_irq) begin
            state          <= RD_ADDR;
            avm_chipselect <= 1'b1;
            avm_address    <= 3'd3;
          end else if (cmd_valid) begin
            state          <= CMD_WR;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= op_addr(cmd_op);
            avm_writedata  <= 32'(cmd_data);
          end
        end
        CMD_WR: begin
          last_irq <= 1'b0;
          state    <= IDLE;
        end
        RD_ADDR: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            capture <= rd_masked[WIDTH-1:0];
            if (rd_masked == '0) begin
              state <= IDLE;
            end else begin
              state          <= CLR_WR;
              avm_chipselect <= 1'b1;
              avm_write_n    <= 1'b0;
              avm_address    <= 3'd3;
              avm_writedata  <= rd_masked;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        CLR_WR: begin
          last_irq <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry event buffer; merges services while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid    <= 1'b0;
      evt_bits     <= '0;
      evt_overflow <= 1'b0;
    end else if (post) begin
      evt_valid <= 1'b1;
      if (evt_valid && !evt_ready) begin
        evt_bits     <= evt_bits | capture;
        evt_overflow <= 1'b1;
      end else begin
        evt_bits     <= capture;
        evt_overflow <= 1'b0;
      end
    end else if (evt_hs) begin
      evt_valid    <= 1'b0;
      evt_bits     <= '0;
      evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Bench for pio_irq_service_master: PIO responder model, bus monitor,
// directed scenarios and a randomized run against an abstract model.
module tb_pio_irq_service_master;

  typedef struct packed {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    int         cyc;
  } op_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq_in;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_data = 8'h00;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  evt_bits;
  logic        evt_overflow;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        busy;

  logic [7:0]  pin_in = 8'h00;
  logic        force_zero = 1'b0;
  logic [7:0]  pin_prev, p_data, p_dir, p_mask, p_edge;

  op_t ops[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;

  always #5 clk = ~clk;

  pio_irq_service_master #(
    .WIDTH(8),
    .DIR_INIT(8'h0F),
    .IRQ_MASK_INIT(8'hF0),
    .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .irq_in(irq_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_bits(evt_bits),
    .evt_overflow(evt_overflow),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .busy(busy)
  );

  assign irq_in = |(p_edge & p_mask);

  // PIO responder: rising-edge capture, write-1-to-clear, 1-cycle reads.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_prev <= 8'h00;
      p_data <= 8'h00;
      p_dir <= 8'h00;
      p_mask <= 8'h00;
      p_edge <= 8'h00;
      avm_readdata <= 32'h0;
    end else begin
      pin_prev <= pin_in;
      avm_readdata <= 32'h0;
      if (avm_chipselect && !avm_write_n && avm_address == 3'd3)
        p_edge <= (p_edge & ~avm_writedata[7:0]) | (pin_in & ~pin_prev);
      else if (avm_chipselect && avm_write_n && avm_address == 3'd3 && force_zero)
        p_edge <= 8'h00;
      else
        p_edge <= p_edge | (pin_in & ~pin_prev);
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: p_data <= avm_writedata[7:0];
          3'd1: p_dir <= avm_writedata[7:0];
          3'd2: p_mask <= avm_writedata[7:0];
          3'd4: p_data <= p_data | avm_writedata[7:0];
          3'd5: p_data <= p_data & ~avm_writedata[7:0];
          default: ;
        endcase
      end
      if (avm_chipselect && avm_write_n && avm_address == 3'd3)
        avm_readdata <= force_zero ? 32'h0 : {24'h0, p_edge};
    end
  end

  // Bus monitor: every transfer in order with its cycle stamp.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_chipselect)
      ops.push_back({~avm_write_n, avm_address, avm_writedata[7:0], cyc});
  end

  function automatic logic [2:0] op2addr(input logic [1:0] op);
    case (op)
      2'b00: return 3'd0;
      2'b01: return 3'd4;
      2'b10: return 3'd5;
      default: return 3'd1;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] p);
    pin_in = p;
    tick();
    pin_in = 8'h00;
  endtask

  task automatic test_reset;
    int base, n;
    reset_n = 1'b0;
    tick();
    tick();
    nvec++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
      nerr++;
      $display("FAIL reset_bus got cs=%b wn=%b a=%0d wd=%h", avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    nvec++;
    if ({evt_valid, evt_bits, evt_overflow, cmd_ready, busy} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_ctl got v=%b b=%h o=%b rdy=%b busy=%b", evt_valid, evt_bits, evt_overflow, cmd_ready, busy);
    end
    base = ops.size();
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL init_done busy=%b expected 0", busy);
    end
    nvec++;
    if (ops.size() - base != 2) begin
      nerr++;
      $display("FAIL init_count got %0d transfers expected 2", ops.size() - base);
    end else begin
      nvec++;
      if ({ops[base].w, ops[base].a, ops[base].d, ops[base+1].w, ops[base+1].a, ops[base+1].d}
          !== {1'b1, 3'd1, 8'h0F, 1'b1, 3'd2, 8'hF0}) begin
        nerr++;
        $display("FAIL init_writes got a=%0d d=%h a=%0d d=%h expected 1/0F 2/F0",
                 ops[base].a, ops[base].d, ops[base+1].a, ops[base+1].d);
      end
      nvec++;
      if (ops[base+1].cyc - ops[base].cyc != 1) begin
        nerr++;
        $display("FAIL init_adjacent gap=%0d expected 1", ops[base+1].cyc - ops[base].cyc);
      end
    end
  endtask

  task automatic test_single_edge;
    int base, n;
    base = ops.size();
    evt_ready = 1'b0;
    pulse(8'h10);
    nvec++;
    if (irq_in !== 1'b1) begin
      nerr++;
      $display("FAIL irq_rise irq=%b expected 1", irq_in);
    end
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    nvec++;
    if (n != 4) begin
      nerr++;
      $display("FAIL evt_latency got %0d expected 4", n);
    end
    nvec++;
    if ({evt_valid, evt_bits, evt_overflow, irq_in} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL single_evt got v=%b b=%h o=%b irq=%b expected 1 10 0 0",
               evt_valid, evt_bits, evt_overflow, irq_in);
    end
    nvec++;
    if (ops.size() - base != 2) begin
      nerr++;
      $display("FAIL single_ops got %0d transfers expected 2", ops.size() - base);
    end else begin
      nvec++;
      if ({ops[base].w, ops[base].a, ops[base+1].w, ops[base+1].a, ops[base+1].d}
          !== {1'b0, 3'd3, 1'b1, 3'd3, 8'h10}) begin
        nerr++;
        $display("FAIL single_seq got w%b a%0d then w%b a%0d d=%h expected rd3 then wr3 10",
                 ops[base].w, ops[base].a, ops[base+1].w, ops[base+1].a, ops[base+1].d);
      end
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    nvec++;
    if (evt_valid !== 1'b0) begin
      nerr++;
      $display("FAIL single_hs evt_valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow;
    int n;
    evt_ready = 1'b0;
    pulse(8'h10);
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    pulse(8'h20);
    repeat (8) tick();
    nvec++;
    if ({evt_valid, evt_bits, evt_overflow} !== {1'b1, 8'h30, 1'b1}) begin
      nerr++;
      $display("FAIL overflow_merge got v=%b b=%h o=%b expected 1 30 1", evt_valid, evt_bits, evt_overflow);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    nvec++;
    if ({evt_valid, evt_bits, evt_overflow} !== {1'b0, 8'h00, 1'b0}) begin
      nerr++;
      $display("FAIL overflow_hs got v=%b b=%h o=%b expected 0 00 0", evt_valid, evt_bits, evt_overflow);
    end
  endtask

  task automatic test_fairness;
    int base, n, idx;
    logic t;
    logic seen;
    evt_ready = 1'b1;
    base = ops.size();
    t = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      pin_in = {t, ~t, 6'b0};
      t = ~t;
      tick();
      n++;
      for (int i = base; i < ops.size(); i++)
        if (!ops[i].w) seen = 1'b1;
    end
    cmd_op = 2'b01;
    cmd_data = 8'h81;
    cmd_valid = 1'b1;
    n = 0;
    while (n < 40) begin
      pin_in = {t, ~t, 6'b0};
      t = ~t;
      tick();
      n++;
      if (cmd_ready) break;
    end
    pin_in = {t, ~t, 6'b0};
    t = ~t;
    tick();
    cmd_valid = 1'b0;
    nvec++;
    if (n >= 40) begin
      nerr++;
      $display("FAIL fair_accept cmd never accepted in %0d cycles", n);
    end
    repeat (10) begin
      pin_in = {t, ~t, 6'b0};
      t = ~t;
      tick();
    end
    pin_in = 8'h00;
    n = 0;
    while ((busy || irq_in || evt_valid) && n < 60) begin
      tick();
      n++;
    end
    idx = -1;
    for (int i = base; i < ops.size(); i++)
      if (ops[i].w && ops[i].a == 3'd4) idx = i;
    nvec++;
    if (idx <= base || idx >= ops.size() - 1) begin
      nerr++;
      $display("FAIL fair_cmd_pos idx=%0d base=%0d size=%0d", idx, base, ops.size());
    end else begin
      nvec++;
      if ({ops[idx-1].w, ops[idx-1].a, ops[idx].d, ops[idx+1].w, ops[idx+1].a}
          !== {1'b1, 3'd3, 8'h81, 1'b0, 3'd3}) begin
        nerr++;
        $display("FAIL fair_order got prev w%b a%0d cmd d=%h next w%b a%0d expected wr3 81 rd3",
                 ops[idx-1].w, ops[idx-1].a, ops[idx].d, ops[idx+1].w, ops[idx+1].a);
      end
    end
    nvec++;
    if (p_data !== 8'h81) begin
      nerr++;
      $display("FAIL fair_pio_data got %h expected 81", p_data);
    end
  endtask

  task automatic test_spurious;
    int base, rd, wr;
    base = ops.size();
    force_zero = 1'b1;
    pulse(8'h10);
    repeat (10) tick();
    force_zero = 1'b0;
    rd = 0;
    wr = 0;
    for (int i = base; i < ops.size(); i++)
      if (ops[i].w) wr++;
      else if (ops[i].a == 3'd3) rd++;
    nvec++;
    if (rd != 1 || wr != 0) begin
      nerr++;
      $display("FAIL spurious_ops got reads=%0d writes=%0d expected 1 0", rd, wr);
    end
    nvec++;
    if ({evt_valid, busy, irq_in} !== 3'b000) begin
      nerr++;
      $display("FAIL spurious_state got v=%b busy=%b irq=%b expected 0 0 0", evt_valid, busy, irq_in);
    end
  endtask

  task automatic test_reset_abort;
    int base, n;
    evt_ready = 1'b0;
    pulse(8'h10);
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    pulse(8'h20);
    n = 0;
    while (!(avm_chipselect && avm_write_n) && n < 20) begin
      tick();
      n++;
    end
    nvec++;
    if (n >= 20) begin
      nerr++;
      $display("FAIL abort_read no read phase within %0d cycles", n);
    end
    tick();
    reset_n = 1'b0;
    #1;
    nvec++;
    if ({avm_chipselect, evt_valid, evt_bits, evt_overflow, busy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL abort_async got cs=%b v=%b b=%h o=%b busy=%b expected 0 0 00 0 1",
               avm_chipselect, evt_valid, evt_bits, evt_overflow, busy);
    end
    tick();
    tick();
    base = ops.size();
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    tick();
    nvec++;
    if (ops.size() - base < 2) begin
      nerr++;
      $display("FAIL abort_reinit got %0d transfers expected >=2", ops.size() - base);
    end else begin
      nvec++;
      if ({ops[base].a, ops[base].d, ops[base+1].a, ops[base+1].d} !== {3'd1, 8'h0F, 3'd2, 8'hF0}) begin
        nerr++;
        $display("FAIL abort_init_writes got a=%0d d=%h a=%0d d=%h expected 1/0F 2/F0",
                 ops[base].a, ops[base].d, ops[base+1].a, ops[base+1].d);
      end
    end
  endtask

  task automatic test_random;
    op_t        expq[$];
    logic [7:0] eu, got, clr, prevp, newp, d;
    logic [1:0] op;
    logic       acc;
    int         base, k, m;
    base = ops.size();
    eu = 8'h00;
    got = 8'h00;
    prevp = pin_in;
    acc = 1'b0;
    for (int i = 0; i < 480; i++) begin
      if (cmd_valid && cmd_ready) acc = 1'b1;
      evt_ready = (i >= 400) ? 1'b1 : 1'($urandom % 2);
      if (evt_valid && evt_ready) begin
        got = got | evt_bits;
        nvec++;
        if (evt_bits == 8'h00) begin
          nerr++;
          $display("FAIL rand_evt_zero handshake with evt_bits=00 at step %0d", i);
        end
      end
      newp = (i < 400 && $urandom % 3 == 0) ? {4'($urandom), 4'h0} : 8'h00;
      eu = eu | (newp & ~prevp);
      prevp = newp;
      pin_in = newp;
      tick();
      if (acc) begin
        cmd_valid = 1'b0;
        acc = 1'b0;
      end
      if (!cmd_valid && i < 400 && $urandom % 4 == 0) begin
        op = 2'($urandom);
        d = 8'($urandom);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        expq.push_back({1'b1, op2addr(op), d, 32'd0});
      end
      #1;
    end
    evt_ready = 1'b0;
    clr = 8'h00;
    k = 0;
    m = 0;
    for (int i = base; i < ops.size(); i++) begin
      if (ops[i].w && ops[i].a == 3'd3) clr = clr | ops[i].d;
      if (ops[i].w && ops[i].a != 3'd3) begin
        if (k < expq.size()) begin
          nvec++;
          if ({ops[i].a, ops[i].d} !== {expq[k].a, expq[k].d}) begin
            nerr++;
            m++;
            $display("FAIL rand_cmd[%0d] got a=%0d d=%h expected a=%0d d=%h",
                     k, ops[i].a, ops[i].d, expq[k].a, expq[k].d);
          end
        end
        k++;
      end
    end
    nvec++;
    if (k != expq.size()) begin
      nerr++;
      $display("FAIL rand_cmd_count got %0d expected %0d", k, expq.size());
    end
    nvec++;
    if (got !== eu) begin
      nerr++;
      $display("FAIL rand_evt_union got %h expected %h", got, eu);
    end
    nvec++;
    if (clr !== eu) begin
      nerr++;
      $display("FAIL rand_clr_union got %h expected %h", clr, eu);
    end
    nvec++;
    if ({cmd_valid, evt_valid, busy, p_edge} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      nerr++;
      $display("FAIL rand_drain got cv=%b ev=%b busy=%b edge=%h expected 0 0 0 00",
               cmd_valid, evt_valid, busy, p_edge);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_overflow();
    test_fairness();
    test_spurious();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
